// File: rtl/ristretto_prefetch_buffer.sv
// ristretto_prefetch_buffer: instruction prefetch FIFO with credit-limited fetch FSM and branch discard.
// Define RISTRETTO_PF_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module ristretto_prefetch_buffer #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WRDY, WVLD} state_t;

    state_t          state;
    logic [31:0]     fetch_addr, branch_tgt, tgt_in;
    logic            branch_pend;
    logic [CW-1:0]   count, outs, disc, count_nxt, outs_nxt;
    logic [AW-1:0]   rd_ptr, wr_ptr, pa_rd, pa_wr;
    logic [31:0]     fifo_data [DEPTH];
    logic [31:0]     fifo_addr [DEPTH];
    logic [31:0]     pend_addr [DEPTH];
    logic            gnt, drop, accept, bypass, push, pop, credit, credit_nxt, not_empty;

    assign tgt_in     = branch_addr_i & 32'hFFFF_FFFC;
    assign imem_req_o = state == WRDY;
    assign imem_addr_o = fetch_addr;
    assign gnt        = imem_req_o & imem_gnt_i;
    assign drop       = branch_i | (disc != '0);
    assign accept     = imem_rvalid_i & ~drop;
    assign not_empty  = count != '0;
`ifdef RISTRETTO_PF_BYPASS_EN
    assign bypass     = accept & instr_ready_i & ~not_empty;
`else
    assign bypass     = 1'b0;
`endif
    assign push       = accept & ~bypass;
    assign instr_valid_o = (not_empty | bypass) & ~branch_i;
    assign pop        = instr_valid_o & instr_ready_i & not_empty;
    assign instr_rdata_o = not_empty ? fifo_data[rd_ptr] : bypass ? imem_rdata_i : '0;
    assign instr_addr_o  = not_empty ? fifo_addr[rd_ptr] : bypass ? pend_addr[pa_rd] : '0;
    assign busy_o     = not_empty | (outs != '0);

    assign count_nxt  = branch_i ? '0 : count + CW'(push) - CW'(pop);
    assign outs_nxt   = outs + CW'(gnt) - CW'(imem_rvalid_i);
    assign credit     = ({1'b0, count} + {1'b0, outs}) < (CW+1)'(DEPTH);
    assign credit_nxt = ({1'b0, count_nxt} + {1'b0, outs_nxt}) < (CW+1)'(DEPTH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            fetch_addr  <= BOOT_ADDR;
            branch_tgt  <= '0;
            branch_pend <= 1'b0;
            count       <= '0;
            outs        <= '0;
            disc        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pa_rd       <= '0;
            pa_wr       <= '0;
        end else begin
            case (state)
                IDLE, WVLD: if (fetch_en_i && credit) state <= WRDY;
                WRDY:       if (gnt) state <= !fetch_en_i ? IDLE : credit_nxt ? WRDY : WVLD;
                default:    state <= IDLE;
            endcase
            // A request caught by a branch before its grant still goes out at the old address.
            if (gnt)
                fetch_addr <= branch_i ? tgt_in : branch_pend ? branch_tgt : fetch_addr + 32'd4;
            else if (branch_i && !imem_req_o)
                fetch_addr <= tgt_in;
            branch_pend <= gnt ? 1'b0 : branch_pend | (branch_i & imem_req_o);
            branch_tgt  <= branch_i ? tgt_in : branch_tgt;
            disc <= branch_i ? outs + CW'(gnt) - CW'(imem_rvalid_i)
                             : disc - CW'(imem_rvalid_i && disc != '0) + CW'(gnt && branch_pend);
            count  <= count_nxt;
            outs   <= outs_nxt;
            pa_wr  <= pa_wr + AW'(gnt);
            pa_rd  <= pa_rd + AW'(imem_rvalid_i);
            rd_ptr <= branch_i ? '0 : rd_ptr + AW'(pop);
            wr_ptr <= branch_i ? '0 : wr_ptr + AW'(push);
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt) pend_addr[pa_wr] <= fetch_addr;
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata_i;
            fifo_addr[wr_ptr] <= pend_addr[pa_rd];
        end
    end

    no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && count == CW'(DEPTH)));
endmodule

// File: doc/ristretto_prefetch_buffer.md
RISTRETTO_PREFETCH_BUFFER -- requirements
Module: ristretto_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entries; legal values 4, 8, 16, 32.
REQ-002 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first fetch address (word aligned).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_en_i  input  1  enables fetching.
REQ-006 SHALL have port branch_i  input  1  redirect pulse, one cycle.
REQ-007 SHALL have port branch_addr_i  input  32  redirect target; bits [1:0] ignored.
REQ-008 SHALL have port imem_req_o  output  1  fetch request to instruction memory.
REQ-009 SHALL have port imem_addr_o  output  32  fetch address, bits [1:0] always 0.
REQ-010 SHALL have port imem_gnt_i  input  1  request accepted when imem_req_o & imem_gnt_i.
REQ-011 SHALL have port imem_rvalid_i  input  1  response valid, in-order, one per granted request.
REQ-012 SHALL have port imem_rdata_i  input  32  response instruction word.
REQ-013 SHALL have port instr_valid_o  output  1  instruction available to decode.
REQ-014 SHALL have port instr_ready_i  input  1  decode accepts; pop when valid & ready.
REQ-015 SHALL have port instr_rdata_o  output  32  head instruction word.
REQ-016 SHALL have port instr_addr_o  output  32  head instruction address.
REQ-017 SHALL have port busy_o  output  1  high when outstanding requests or buffered entries are non-zero.

Function
REQ-018 SHALL hold a request FSM: IDLE (req low), WRDY (req high, awaiting gnt), WVLD (credit exhausted, awaiting rvalid/pop).
REQ-019 SHALL move IDLE->WRDY when fetch_en_i=1 and credit available; credit = count + outstanding < DEPTH.
REQ-020 SHALL, in WRDY, hold imem_req_o and imem_addr_o stable until imem_gnt_i; a request is never withdrawn, including on branch_i.
REQ-021 SHALL, on grant, increment fetch address by 4 (wrap 32'hFFFF_FFFC->0), increment outstanding, and stay in WRDY if credit remains, go to WVLD if not, go to IDLE if fetch_en_i=0.
REQ-022 SHALL move WVLD->WRDY the cycle after credit becomes available and fetch_en_i=1.
REQ-023 SHALL push {rdata, address} into FIFO on imem_rvalid_i unless discarded; decrement outstanding on every rvalid.
REQ-024 SHALL track response addresses in a pending-address queue, depth DEPTH, in grant order.
REQ-025 SHALL present FIFO head on instr_*_o; instr_valid_o = FIFO non-empty & !branch_i.
REQ-026 SHALL, on branch_i: clear FIFO, set discard counter = outstanding (+1 if a grant occurs that cycle, + rvalid adjustment), set next fetch address = {branch_addr_i[31:2],2'b00}.
REQ-027 SHALL drop responses while discard counter > 0, decrementing it per rvalid; rvalid in the branch cycle is dropped.
REQ-028 SHALL, if branch_i arrives in WRDY without grant, complete that request at the old address, discard its response, then issue branch target.
REQ-029 SHALL ignore a pop coincident with branch_i; a second branch_i before discards finish accumulates discards correctly.
REQ-030 SHALL never overflow: push on full FIFO is unreachable by credit rule; assertion flags it.
REQ-031 SHALL keep count and outstanding counters $clog2(DEPTH)+1 bits wide.

Reset
REQ-032 SHALL on rst_ni=0, asynchronously: FSM=IDLE, imem_req_o=0, imem_addr_o=BOOT_ADDR, FIFO empty, instr_valid_o=0, instr_rdata_o=0, instr_addr_o=0, outstanding=0, discard=0, busy_o=0.
REQ-033 SHALL, on reset asserted mid-transaction, drop all state; responses after release are not expected by the bench.

Configuration
REQ-034 SHALL support macro RISTRETTO_PF_BYPASS_EN.
REQ-035 With macro: when FIFO empty, non-discarded rvalid with instr_ready_i=1 drives instr_*_o combinationally same cycle, no push; latency rvalid->valid 0 cycles.
REQ-036 Without macro: every response is pushed; instr_valid_o rises one cycle after rvalid.

Verification
REQ-037 Reset release, fetch_en_i=1, gnt always 1, rvalid 1 cycle after gnt -> addresses 0x0,0x4,0x8,0xC in order, instr_addr_o matches.
REQ-038 DEPTH=4, instr_ready_i=0 -> exactly 4 grants then FSM WVLD, imem_req_o=0; one pop -> one new request.
REQ-039 imem_gnt_i low 3 cycles -> imem_addr_o constant 0x10 for all 3 cycles.
REQ-040 3 outstanding, branch_i to 0x203 -> 3 responses dropped, next request addr 0x200, first instr_addr_o 0x200.
REQ-041 Branch while WRDY ungranted at 0x8 -> 0x8 granted, response dropped, next request 0x40 target.
REQ-042 With RISTRETTO_PF_BYPASS_EN, empty FIFO, rvalid data 0x00000013, ready=1 -> instr_valid_o=1 same cycle; without, next cycle.
